pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-002 clk  input  1  rising-edge clock shared with all pipeline registers.
REQ-003 reset  input  1  synchronous, active-high; clears all internal state.
REQ-004 id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd  input  3 each  source register indices of the instruction pair in ID.
REQ-005 id_src_valid  input  4  per-source use mask [3:0] = {mem_rd, mem_rn, alu_rm, alu_rn}.
REQ-006 p2_memRead, p2_mem_regWrite  input  1 each  EX-stage load and writeback control.
REQ-007 p2_mem_rd  input  3  EX-stage load destination.
REQ-008 ex_branch_taken  input  1  branch or jump resolved taken in EX.
REQ-009 ex_undef  input  1  undefined instruction reached EX.
REQ-010 mem_busy  input  1  data memory not ready this cycle.
REQ-011 pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  output  1 each  pipeline register and PC write enables.
REQ-012 if_flush, id_flush, ex_flush, p2_pipeline_stall  output  1 each  flush and bubble controls.
REQ-013 mem_timeout  output  1  sticky error flag.

Function
REQ-014 A load-use hazard SHALL be detected when p2_memRead & p2_mem_regWrite is high and p2_mem_rd equals any ID source whose id_src_valid bit is set.
REQ-015 On a load-use hazard in RUN, the same cycle SHALL drive pc_write=0, if_id_write=0 and p2_pipeline_stall=1 (exactly one bubble per load); all other writes stay 1.
REQ-016 ex_branch_taken in RUN SHALL assert if_flush=1 and id_flush=1 in the same cycle with pc_write=1; the flush overrides any simultaneous load-use stall.
REQ-017 ex_undef SHALL assert if_flush, id_flush and ex_flush for one cycle and override branch and load-use.
REQ-018 The FSM SHALL have the states RUN and MEM_WAIT; RUN goes to MEM_WAIT when mem_busy=1; MEM_WAIT goes to RUN on the first cycle with mem_busy=0.
REQ-019 Whenever mem_busy=1, all five write enables SHALL be 0 and all flushes and the stall SHALL be 0 (full freeze).
REQ-020 ex_branch_taken or ex_undef seen while mem_busy=1 SHALL be latched in pending flags and applied on the release cycle (mem_busy=0 in MEM_WAIT); the flags clear in that cycle.
REQ-021 An 8-bit wait counter SHALL increment each MEM_WAIT cycle and clear on entry to RUN; when it reaches 255, mem_timeout SHALL set and hold until reset.
REQ-022 In the idle case (no hazard), all writes SHALL be 1 and all flushes and the stall SHALL be 0.

Reset
REQ-023 While reset=1, the state SHALL be RUN, the pending flags, wait counter and mem_timeout SHALL be 0, all writes SHALL be 1, and all flushes and the stall SHALL be 0.
REQ-024 Reset asserted during MEM_WAIT SHALL discard any pending flush.

Configuration
REQ-025 Macro HAZARD_PERF_CNT_EN SHALL add 16-bit saturating outputs stall_count (load-use bubbles), flush_count (branch/undef flushes) and freeze_count (mem_busy cycles), all cleared by reset; without the macro, these ports and their logic SHALL be absent.

Structure
REQ-026 The shared package hazard_pkg SHALL hold the FSM state encoding, the WAIT_TIMEOUT=255 constant and the source mask bit positions.
REQ-027 The 3-bit source comparison against p2_mem_rd SHALL be a sub-module named hazard_src_match, instantiated once with a 4-source input and a 1-bit match output.

Verification
REQ-028 p2_memRead=1, p2_mem_regWrite=1, p2_mem_rd=3, id_alu_rm=3, id_src_valid=4'b0010 -> one cycle with pc_write=0, if_id_write=0, p2_pipeline_stall=1.
REQ-029 Same as REQ-028 but with id_src_valid=4'b0000 -> no stall.
REQ-030 ex_branch_taken=1 together with a load-use hazard -> if_flush=1, id_flush=1, pc_write=1, p2_pipeline_stall=0.
REQ-031 mem_busy=1 for 4 cycles with ex_branch_taken pulsed in cycle 2 -> all writes 0 for 4 cycles, then if_flush=1 and id_flush=1 in cycle 5 only.
REQ-032 mem_busy held for 300 cycles -> mem_timeout rises after 255 MEM_WAIT cycles and stays 1 until reset.
REQ-033 Reset asserted mid-MEM_WAIT with a pending ex_undef -> after reset, no flush occurs and the counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared definitions for the pipeline hazard controller
// Purpose: FSM state encoding, wait-timeout constant, ID source mask bit
//          positions and a saturating counter helper.
// Ports:   none (package).
package hazard_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] WAIT_TIMEOUT = 8'd255;

  // Bit positions inside id_src_valid / the packed source vector.
  localparam int SRC_ALU_RN = 0;
  localparam int SRC_ALU_RM = 1;
  localparam int SRC_MEM_RN = 2;
  localparam int SRC_MEM_RD = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - compares four ID source indices against a load destination
// Purpose: reports whether any enabled ID source register equals the EX load
//          destination register.
// Ports:   src[3:0][2:0] - source indices, ordered by hazard_pkg SRC_* positions
//          src_valid[3:0] - per-source use mask
//          rd[2:0]        - EX-stage load destination
//          match          - 1 when an enabled source equals rd
module hazard_src_match import hazard_pkg::*; (
  input  logic [3:0][2:0] src,
  input  logic [3:0]      src_valid,
  input  logic [2:0]      rd,
  output logic            match
);

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (src_valid[i] && src[i] == rd) match = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, flush and memory-freeze control
// Purpose: drives PC / pipeline register write enables, flushes and the bubble
//          control from load-use hazards, taken branches, undefined
//          instructions and data-memory busy; latches flush requests seen
//          during a freeze and flags a sticky memory timeout.
// Ports:   clk, reset (sync, active-high)
//          id_alu_rn/id_alu_rm/id_mem_rn/id_mem_rd, id_src_valid - ID sources
//          p2_memRead, p2_mem_regWrite, p2_mem_rd - EX load info
//          ex_branch_taken, ex_undef, mem_busy - control events
//          pc_write..mem_wb_write - write enables
//          if_flush, id_flush, ex_flush, p2_pipeline_stall - flush/bubble
//          mem_timeout - sticky error
//          stall_count, flush_count, freeze_count - only with HAZARD_PERF_CNT_EN
module pipeline_hazard_ctrl import hazard_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] id_alu_rn,
  input  logic [2:0] id_alu_rm,
  input  logic [2:0] id_mem_rn,
  input  logic [2:0] id_mem_rd,
  input  logic [3:0] id_src_valid,
  input  logic       p2_memRead,
  input  logic       p2_mem_regWrite,
  input  logic [2:0] p2_mem_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_undef,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_write,
  output logic       ex_mem_write,
  output logic       mem_wb_write,
  output logic       if_flush,
  output logic       id_flush,
  output logic       ex_flush,
  output logic       p2_pipeline_stall,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic [15:0] freeze_count
`endif
);

  state_e     state_q, state_d;
  logic       pend_branch_q, pend_branch_d;
  logic       pend_undef_q, pend_undef_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic [3:0][2:0] src_vec;
  logic            src_match;
  logic            load_use;
  logic            eff_branch, eff_undef;

  always_comb begin
    src_vec             = '0;
    src_vec[SRC_ALU_RN] = id_alu_rn;
    src_vec[SRC_ALU_RM] = id_alu_rm;
    src_vec[SRC_MEM_RN] = id_mem_rn;
    src_vec[SRC_MEM_RD] = id_mem_rd;
  end

  hazard_src_match u_src_match (
    .src       (src_vec),
    .src_valid (id_src_valid),
    .rd        (p2_mem_rd),
    .match     (src_match)
  );

  assign load_use = p2_memRead & p2_mem_regWrite & src_match;

  // Pending flags are only ever set during a freeze, so in RUN they are 0 and
  // these reduce to the live EX requests; on the release cycle they replay.
  assign eff_branch = ex_branch_taken | pend_branch_q;
  assign eff_undef  = ex_undef | pend_undef_q;

  always_comb begin
    state_d       = state_q;
    pend_branch_d = pend_branch_q;
    pend_undef_d  = pend_undef_q;
    wait_cnt_d    = wait_cnt_q;
    if (mem_busy) begin
      state_d       = ST_MEM_WAIT;
      pend_branch_d = pend_branch_q | ex_branch_taken;
      pend_undef_d  = pend_undef_q | ex_undef;
      if (state_q == ST_MEM_WAIT && wait_cnt_q != WAIT_TIMEOUT)
        wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      state_d       = ST_RUN;
      pend_branch_d = 1'b0;
      pend_undef_d  = 1'b0;
      wait_cnt_d    = 8'd0;
    end
    timeout_d = timeout_q | (wait_cnt_d == WAIT_TIMEOUT);
  end

  always_comb begin
    pc_write          = 1'b1;
    if_id_write       = 1'b1;
    id_ex_write       = 1'b1;
    ex_mem_write      = 1'b1;
    mem_wb_write      = 1'b1;
    if_flush          = 1'b0;
    id_flush          = 1'b0;
    ex_flush          = 1'b0;
    p2_pipeline_stall = 1'b0;
    if (reset) begin
      // idle outputs while in reset
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (eff_undef) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (eff_branch) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (load_use) begin
      pc_write          = 1'b0;
      if_id_write       = 1'b0;
      p2_pipeline_stall = 1'b1;
    end
  end

  assign mem_timeout = timeout_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pend_branch_q <= 1'b0;
      pend_undef_q  <= 1'b0;
      wait_cnt_q    <= 8'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_branch_q <= pend_branch_d;
      pend_undef_q  <= pend_undef_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic [15:0] freeze_count_q, freeze_count_d;

  always_comb begin
    stall_count_d  = sat_inc16(stall_count_q, p2_pipeline_stall);
    flush_count_d  = sat_inc16(flush_count_q, if_flush);
    freeze_count_d = sat_inc16(freeze_count_q, mem_busy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q  <= 16'd0;
      flush_count_q  <= 16'd0;
      freeze_count_q <= 16'd0;
    end else begin
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
      freeze_count_q <= freeze_count_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;
  assign freeze_count = freeze_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - table-driven and sequence checks for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd;
  logic [3:0] id_src_valid;
  logic       p2_memRead, p2_mem_regWrite;
  logic [2:0] p2_mem_rd;
  logic       ex_branch_taken, ex_undef, mem_busy;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic       if_flush, id_flush, ex_flush, p2_pipeline_stall, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count, flush_count, freeze_count;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .id_alu_rn         (id_alu_rn),
    .id_alu_rm         (id_alu_rm),
    .id_mem_rn         (id_mem_rn),
    .id_mem_rd         (id_mem_rd),
    .id_src_valid      (id_src_valid),
    .p2_memRead        (p2_memRead),
    .p2_mem_regWrite   (p2_mem_regWrite),
    .p2_mem_rd         (p2_mem_rd),
    .ex_branch_taken   (ex_branch_taken),
    .ex_undef          (ex_undef),
    .mem_busy          (mem_busy),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write),
    .id_ex_write       (id_ex_write),
    .ex_mem_write      (ex_mem_write),
    .mem_wb_write      (mem_wb_write),
    .if_flush          (if_flush),
    .id_flush          (id_flush),
    .ex_flush          (ex_flush),
    .p2_pipeline_stall (p2_pipeline_stall),
    .mem_timeout       (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count       (stall_count),
    .flush_count       (flush_count),
    .freeze_count      (freeze_count)
`endif
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_flush, id_flush, ex_flush, stall}
  localparam logic [8:0] O_IDLE   = 9'b11111_000_0;
  localparam logic [8:0] O_STALL  = 9'b00111_000_1;
  localparam logic [8:0] O_BRANCH = 9'b11111_110_0;
  localparam logic [8:0] O_UNDEF  = 9'b11111_111_0;
  localparam logic [8:0] O_FREEZE = 9'b00000_000_0;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] rn, rm, mrn, mrd;
    logic [3:0] valid;
    logic       mr, rw;
    logic [2:0] p2rd;
    logic       br, ud;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied = 0;
  int   miscompares = 0;

  function automatic logic [8:0] outs();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
            if_flush, id_flush, ex_flush, p2_pipeline_stall};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0;
    id_alu_rn = 3'd0; id_alu_rm = 3'd0; id_mem_rn = 3'd0; id_mem_rd = 3'd0;
    id_src_valid = 4'b0000;
    p2_memRead = 1'b0; p2_mem_regWrite = 1'b0; p2_mem_rd = 3'd0;
    ex_branch_taken = 1'b0; ex_undef = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic add(input string name, input logic rst,
                     input logic [2:0] rn, input logic [2:0] rm,
                     input logic [2:0] mrn, input logic [2:0] mrd,
                     input logic [3:0] valid, input logic mr, input logic rw,
                     input logic [2:0] p2rd, input logic br, input logic ud,
                     input logic [8:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.rn = rn; v.rm = rm; v.mrn = mrn; v.mrd = mrd;
    v.valid = valid; v.mr = mr; v.rw = rw; v.p2rd = p2rd; v.br = br; v.ud = ud;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    #1 check("reset_outputs", {23'd0, outs()}, {23'd0, O_IDLE});
    check("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    drive_idle();
    add("idle",             0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, O_IDLE);
    add("lu_alu_rm",        0, 0, 3, 0, 0, 4'b0010, 1, 1, 3, 0, 0, O_STALL);
    add("lu_masked",        0, 0, 3, 0, 0, 4'b0000, 1, 1, 3, 0, 0, O_IDLE);
    add("lu_no_memread",    0, 0, 3, 0, 0, 4'b0010, 0, 1, 3, 0, 0, O_IDLE);
    add("lu_no_regwrite",   0, 0, 3, 0, 0, 4'b0010, 1, 0, 3, 0, 0, O_IDLE);
    add("lu_mem_rd",        0, 0, 0, 0, 5, 4'b1000, 1, 1, 5, 0, 0, O_STALL);
    add("lu_mem_rn",        0, 0, 0, 6, 0, 4'b0100, 1, 1, 6, 0, 0, O_STALL);
    add("lu_alu_rn_mism",   0, 2, 0, 0, 0, 4'b0001, 1, 1, 3, 0, 0, O_IDLE);
    add("lu_other_src_eq",  0, 7, 3, 0, 0, 4'b0001, 1, 1, 3, 0, 0, O_IDLE);
    add("branch_over_lu",   0, 0, 3, 0, 0, 4'b0010, 1, 1, 3, 1, 0, O_BRANCH);
    add("branch_alone",     0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0, O_BRANCH);
    add("undef_over_all",   0, 0, 3, 0, 0, 4'b0010, 1, 1, 3, 1, 1, O_UNDEF);
    add("reset_masks_br",   1, 0, 3, 0, 0, 4'b0010, 1, 1, 3, 1, 1, O_IDLE);

    do_reset();

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      id_alu_rn = vecs[i].rn; id_alu_rm = vecs[i].rm;
      id_mem_rn = vecs[i].mrn; id_mem_rd = vecs[i].mrd;
      id_src_valid = vecs[i].valid;
      p2_memRead = vecs[i].mr; p2_mem_regWrite = vecs[i].rw; p2_mem_rd = vecs[i].p2rd;
      ex_branch_taken = vecs[i].br; ex_undef = vecs[i].ud; mem_busy = 1'b0;
      #1 check(vecs[i].name, {23'd0, outs()}, {23'd0, vecs[i].exp});
    end

    // Freeze for 4 cycles, branch in cycle 2, replayed on release cycle 5.
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      drive_idle();
      mem_busy = (c <= 4);
      ex_branch_taken = (c == 2);
      // a load-use hazard during the freeze must not show as a stall
      p2_memRead = 1'b1; p2_mem_regWrite = 1'b1; p2_mem_rd = 3'd1;
      id_alu_rn = 3'd1; id_src_valid = (c <= 4) ? 4'b0001 : 4'b0000;
      #1;
      if (c <= 4) check($sformatf("freeze_c%0d", c), {23'd0, outs()}, {23'd0, O_FREEZE});
      else if (c == 5) check("release_branch", {23'd0, outs()}, {23'd0, O_BRANCH});
      else check("after_release", {23'd0, outs()}, {23'd0, O_IDLE});
    end

    // Pending undef replays with all three flushes.
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive_idle();
      mem_busy = (c <= 2);
      ex_undef = (c == 1);
      #1;
      if (c == 3) check("release_undef", {23'd0, outs()}, {23'd0, O_UNDEF});
    end

    // Timeout after 255 MEM_WAIT cycles (256 edges with mem_busy high).
    do_reset();
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      drive_idle();
      mem_busy = 1'b1;
      #1;
      if (c == 256) check("timeout_before", {31'd0, mem_timeout}, 32'd0);
      if (c == 257) check("timeout_rise", {31'd0, mem_timeout}, 32'd1);
      if (c == 300) check("timeout_held", {31'd0, mem_timeout}, 32'd1);
    end
    @(negedge clk);
    drive_idle();
    #1 check("timeout_release_outs", {23'd0, outs()}, {23'd0, O_IDLE});
    check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    @(negedge clk);
    #1 check("timeout_sticky_run", {31'd0, mem_timeout}, 32'd1);
    do_reset();
    #1 check("timeout_cleared", {31'd0, mem_timeout}, 32'd0);

    // Reset during MEM_WAIT discards a pending undef.
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive_idle();
      mem_busy = 1'b1;
      ex_undef = (c == 2);
    end
    @(negedge clk);
    drive_idle();
    mem_busy = 1'b1;
    reset = 1'b1;
    #1 check("reset_in_wait_outs", {23'd0, outs()}, {23'd0, O_IDLE});
    @(negedge clk);
    drive_idle();
    #1 check("no_flush_after_reset", {23'd0, outs()}, {23'd0, O_IDLE});
    check("no_timeout_after_reset", {31'd0, mem_timeout}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_count_zero", {16'd0, stall_count}, 32'd0);
    check("flush_count_zero", {16'd0, flush_count}, 32'd0);
    check("freeze_count_zero", {16'd0, freeze_count}, 32'd0);
`endif
    @(negedge clk);
    #1 check("still_idle", {23'd0, outs()}, {23'd0, O_IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
